// File: rtl/gamepad_scanner.sv
// gamepad_scanner
//   Scans a Sega-style multiplexed gamepad once per frame. A rising edge on
//   v_sync_in starts a scan: GP_PIN7_SELECT is driven high then low for
//   SETTLE_CYCLES cycles each and the pad lines are sampled on the last cycle
//   of each phase. At the end of the scan the result is debounced (a bit
//   changes only after two consecutive scans agree) and committed.
//
// Ports
//   CLOCK_50            in   system clock (50 MHz)
//   reset               in   asynchronous, active-high reset
//   v_sync_in           in   frame strobe, rising edge starts a scan
//   GP_PIN*             in   pad lines, active-low
//   GP_PIN7_SELECT      out  pad multiplex select
//   btn_state[11:0]     out  debounced buttons, active-high
//                            [0]up [1]down [2]left [3]right [4]A [5]B
//                            [6]C [7]start [8]X [9]Y [10]Z [11]mode
//   btn_posedge[11:0]   out  one-cycle press pulses, cycle after btn_state rises
//   pad_present         out  pad detected on the last scan
//   frame_done          out  one-cycle pulse when a scan result is committed
//
// Configuration
//   GP_SIX_BUTTON_EN    when defined, scans four select pairs and decodes the
//                       X/Y/Z/mode buttons of six-button pads; otherwise one
//                       pair is scanned and bits [11:8] stay 0.

module gamepad_scanner #(
  parameter int SETTLE_CYCLES = 500
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        v_sync_in,
  input  logic        GP_PIN1_UP_Z,
  input  logic        GP_PIN2_DOWN_Y,
  input  logic        GP_PIN3_LEFT_X,
  input  logic        GP_PIN4_RIGHT_MODE,
  input  logic        GP_PIN6_B_A,
  input  logic        GP_PIN9_C_START,
  output logic        GP_PIN7_SELECT,
  output logic [11:0] btn_state,
  output logic [11:0] btn_posedge,
  output logic        pad_present,
  output logic        frame_done
);

`ifdef GP_SIX_BUTTON_EN
  localparam int          NPAIRS    = 4;
  localparam logic [11:0] KEEP_MASK = 12'hFFF;
`else
  localparam int          NPAIRS    = 1;
  localparam logic [11:0] KEEP_MASK = 12'h0FF;
`endif
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEL_HI, SEL_LO, COMMIT} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    pair_q;
  logic [6:0]    meta_q;
  logic [6:0]    sync_q;      // [5:0] pad lines (pin1,2,3,4,6,9), [6] v_sync
  logic          vs_prev_q;
  logic          sel_q;
  logic [11:0]   raw_q, raw_d;
  logic          cand_q, cand_d;
  logic          six_q, six_d;
  logic [11:0]   hist_q;
  logic [11:0]   btn_state_q, btn_prev_q, btn_posedge_q;
  logic          pad_present_q, frame_done_q;

  logic [5:0]    pad_s;
  logic          phase_end_s, last_pair_s, commit_s, vs_rise_s;
  logic [11:0]   scan_s, state_new_s, hist_new_s;

  assign pad_s       = sync_q[5:0];
  assign phase_end_s = (cnt_q == CW'(SETTLE_CYCLES - 1));
  assign last_pair_s = (pair_q == 2'(NPAIRS - 1));
  assign commit_s    = (state_q == SEL_LO) && phase_end_s && last_pair_s;
  assign vs_rise_s   = sync_q[6] & ~vs_prev_q;

  // Merge the sample of the current phase into the scan being assembled.
  always_comb begin
    raw_d  = raw_q;
    cand_d = cand_q;
    six_d  = six_q;
    if (phase_end_s && (state_q == SEL_HI)) begin
      if (pair_q == 2'd0) begin
        raw_d[0] = ~pad_s[0];
        raw_d[1] = ~pad_s[1];
        raw_d[2] = ~pad_s[2];
        raw_d[3] = ~pad_s[3];
        raw_d[5] = ~pad_s[4];
        raw_d[6] = ~pad_s[5];
      end else if ((pair_q == 2'd3) && six_q) begin
        raw_d[10] = ~pad_s[0];
        raw_d[9]  = ~pad_s[1];
        raw_d[8]  = ~pad_s[2];
        raw_d[11] = ~pad_s[3];
      end else begin
        raw_d = raw_q;
      end
    end else if (phase_end_s && (state_q == SEL_LO)) begin
      if (pair_q == 2'd0) begin
        raw_d[4] = ~pad_s[4];
        raw_d[7] = ~pad_s[5];
        cand_d   = ~pad_s[2] & ~pad_s[3];
      end else if (pair_q == 2'd2) begin
        // Six-button pads pull all four direction lines low in this phase.
        six_d = (pad_s[3:0] == 4'b0000);
      end else begin
        six_d = six_q;
      end
    end else begin
      raw_d = raw_q;
    end
  end

  // Two-scan debounce; a missing pad clears state and history outright.
  always_comb begin
    scan_s      = raw_d & KEEP_MASK;
    state_new_s = 12'h000;
    hist_new_s  = 12'h000;
    if (cand_d) begin
      hist_new_s  = scan_s;
      state_new_s = (btn_state_q & (scan_s ^ hist_q)) | (scan_s & ~(scan_s ^ hist_q));
    end else begin
      hist_new_s  = 12'h000;
      state_new_s = 12'h000;
    end
  end

  // Synchronizers, scan FSM, debounce state and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      meta_q        <= 7'h00;
      sync_q        <= 7'h00;
      vs_prev_q     <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      pair_q        <= 2'd0;
      sel_q         <= 1'b1;
      raw_q         <= 12'h000;
      cand_q        <= 1'b0;
      six_q         <= 1'b0;
      hist_q        <= 12'h000;
      btn_state_q   <= 12'h000;
      btn_prev_q    <= 12'h000;
      btn_posedge_q <= 12'h000;
      pad_present_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      meta_q        <= {v_sync_in, GP_PIN9_C_START, GP_PIN6_B_A, GP_PIN4_RIGHT_MODE,
                        GP_PIN3_LEFT_X, GP_PIN2_DOWN_Y, GP_PIN1_UP_Z};
      sync_q        <= meta_q;
      vs_prev_q     <= sync_q[6];
      raw_q         <= raw_d;
      cand_q        <= cand_d;
      six_q         <= six_d;
      frame_done_q  <= 1'b0;
      // Press pulse lags the state change by one cycle.
      btn_prev_q    <= btn_state_q;
      btn_posedge_q <= btn_state_q & ~btn_prev_q;
      case (state_q)
        IDLE: begin
          sel_q <= 1'b1;
          if (vs_rise_s) begin
            state_q <= SEL_HI;
            cnt_q   <= '0;
            pair_q  <= 2'd0;
            raw_q   <= 12'h000;
            cand_q  <= 1'b0;
            six_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        SEL_HI: begin
          if (phase_end_s) begin
            state_q <= SEL_LO;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SEL_LO: begin
          if (commit_s) begin
            state_q       <= COMMIT;
            cnt_q         <= '0;
            sel_q         <= 1'b1;
            btn_state_q   <= state_new_s;
            hist_q        <= hist_new_s;
            pad_present_q <= cand_d;
            frame_done_q  <= 1'b1;
          end else if (phase_end_s) begin
            state_q <= SEL_HI;
            cnt_q   <= '0;
            sel_q   <= 1'b1;
            pair_q  <= pair_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          sel_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= 1'b1;
        end
      endcase
    end
  end

  assign GP_PIN7_SELECT = sel_q;
  assign btn_state      = btn_state_q & KEEP_MASK;
  assign btn_posedge    = btn_posedge_q & KEEP_MASK;
  assign pad_present    = pad_present_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_gamepad_scanner.sv
// Self-checking bench for gamepad_scanner with SETTLE_CYCLES=4.
// A pad model drives the lines from a pad type and a pressed-button set;
// a scan-level model predicts btn_state/pad_present/btn_posedge per frame.

module tb_gamepad_scanner;
  localparam int S = 4;
`ifdef GP_SIX_BUTTON_EN
  localparam bit SIX = 1'b1;
`else
  localparam bit SIX = 1'b0;
`endif
  localparam int BUDGET = SIX ? (8 * S + 5) : (2 * S + 5);

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        v_sync_in = 1'b0;
  logic [5:0]  pins;          // [0]p1 [1]p2 [2]p3 [3]p4 [4]p6 [5]p9
  logic        sel;
  logic [11:0] btn_state, btn_posedge;
  logic        pad_present, frame_done;

  int          n_checks = 0;
  int          n_fail = 0;
  int          pad_type = 0;  // 0 absent, 3 three-button, 6 six-button
  logic [11:0] pressed = 12'h000;
  int          falls = 0;

  logic [11:0] exp_state = 12'h000, exp_hist = 12'h000, exp_pulse = 12'h000;
  logic        exp_present = 1'b0;
  int          frames = 0, pulses = 0;
  logic [11:0] last_pulse = 12'h000;
  logic        fd_prev = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  gamepad_scanner #(.SETTLE_CYCLES(S)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .v_sync_in(v_sync_in),
    .GP_PIN1_UP_Z(pins[0]), .GP_PIN2_DOWN_Y(pins[1]), .GP_PIN3_LEFT_X(pins[2]),
    .GP_PIN4_RIGHT_MODE(pins[3]), .GP_PIN6_B_A(pins[4]), .GP_PIN9_C_START(pins[5]),
    .GP_PIN7_SELECT(sel), .btn_state(btn_state), .btn_posedge(btn_posedge),
    .pad_present(pad_present), .frame_done(frame_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Select-low phases seen in the current scan, as a real pad counts them.
  always @(negedge sel or posedge frame_done or posedge reset)
    if (reset || frame_done) falls <= 0;
    else falls <= falls + 1;

  // Pad line model.
  always_comb begin
    pins = 6'b111111;
    if (pad_type != 0) begin
      if (sel) begin
        if (pad_type == 6 && falls == 3)
          pins = {~pressed[6], ~pressed[5], ~pressed[11], ~pressed[8], ~pressed[9], ~pressed[10]};
        else
          pins = {~pressed[6], ~pressed[5], ~pressed[3], ~pressed[2], ~pressed[1], ~pressed[0]};
      end else begin
        if (pad_type == 6 && falls == 3)
          pins = {~pressed[7], ~pressed[4], 4'b0000};
        else if (pad_type == 6 && falls == 4)
          pins = {~pressed[7], ~pressed[4], 4'b1111};
        else
          pins = {~pressed[7], ~pressed[4], 1'b0, 1'b0, ~pressed[1], ~pressed[0]};
      end
    end else begin
      pins = 6'b111111;
    end
  end

  function automatic logic [11:0] model_scan(input int pt, input logic [11:0] pr);
    if (pt == 0) return 12'h000;
    if (pt == 6 && SIX) return pr;
    return pr & 12'h0FF;
  endfunction

  // Scan-level model and per-cycle comparison.
  initial begin
    logic [11:0] scan, old;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        exp_state = 12'h000; exp_hist = 12'h000; exp_pulse = 12'h000;
        exp_present = 1'b0; fd_prev = 1'b0;
      end else begin
        if (frame_done) begin
          frames++;
          scan = model_scan(pad_type, pressed);
          if (pad_type == 0) begin
            exp_state = 12'h000; exp_hist = 12'h000; exp_present = 1'b0; exp_pulse = 12'h000;
          end else begin
            old = exp_state;
            for (int i = 0; i < 12; i++)
              if (scan[i] == exp_hist[i]) exp_state[i] = scan[i];
            exp_hist = scan; exp_present = 1'b1; exp_pulse = exp_state & ~old;
          end
        end
        if (btn_posedge != 12'h000) begin
          pulses++;
          last_pulse = btn_posedge;
        end
        check("btn_state", {20'd0, btn_state}, {20'd0, exp_state});
        check("pad_present", {31'd0, pad_present}, {31'd0, exp_present});
        check("btn_posedge", {20'd0, btn_posedge}, {20'd0, (fd_prev ? exp_pulse : 12'h000)});
        check("frame_done_width", {31'd0, fd_prev & frame_done}, 32'd0);
        fd_prev = frame_done;
      end
    end
  end

  // One scan; optionally re-pulses v_sync while the scan is in its high phase.
  task automatic do_scan(input bit again);
    int n;
    bit seen;
    @(posedge CLOCK_50); #1;
    v_sync_in = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < BUDGET + 3) begin
      @(negedge CLOCK_50);
      n++;
      if (frame_done) seen = 1'b1;
      if (n == 2) v_sync_in = 1'b0;
      if (again && n == 3) v_sync_in = 1'b1;
      if (again && n == 5) v_sync_in = 1'b0;
    end
    v_sync_in = 1'b0;
    check("scan_latency", {31'd0, seen && (n <= BUDGET)}, 32'd1);
    repeat (4) @(negedge CLOCK_50);
  endtask

  initial begin
    int f0, p0, n;
    repeat (3) @(negedge CLOCK_50);
    check("rst_select", {31'd0, sel}, 32'd1);
    check("rst_btn_state", {20'd0, btn_state}, 32'h000);
    check("rst_posedge", {20'd0, btn_posedge}, 32'h000);
    check("rst_pad_present", {31'd0, pad_present}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // Pad absent: three scans, nothing reported.
    f0 = frames;
    repeat (3) do_scan(1'b0);
    check("absent_frames", frames - f0, 32'd3);
    check("absent_state", {20'd0, btn_state}, 32'h000);
    check("absent_present", {31'd0, pad_present}, 32'd0);

    // A held across scans.
    pad_type = 3; pressed = 12'h010;
    p0 = pulses;
    do_scan(1'b0);
    check("a_scan1_state", {20'd0, btn_state}, 32'h000);
    check("a_scan1_present", {31'd0, pad_present}, 32'd1);
    do_scan(1'b0);
    check("a_scan2_state", {20'd0, btn_state}, 32'h010);
    check("a_scan2_pulse", {20'd0, last_pulse}, 32'h010);
    check("a_scan2_pulses", pulses - p0, 32'd1);
    do_scan(1'b0);
    check("a_scan3_pulses", pulses - p0, 32'd1);

    // Released, then a single-scan press of A.
    pressed = 12'h000;
    do_scan(1'b0);
    check("release1_state", {20'd0, btn_state}, 32'h010);
    do_scan(1'b0);
    check("release2_state", {20'd0, btn_state}, 32'h000);
    p0 = pulses;
    pressed = 12'h010;
    do_scan(1'b0);
    pressed = 12'h000;
    do_scan(1'b0);
    check("glitch_state", {20'd0, btn_state}, 32'h000);
    check("glitch_pulses", pulses - p0, 32'd0);

    // Two buttons pressed together.
    pressed = 12'h041;
    do_scan(1'b0);
    do_scan(1'b0);
    check("dual_state", {20'd0, btn_state}, 32'h041);
    check("dual_pulse", {20'd0, last_pulse}, 32'h041);

    // v_sync pulse during the high phase is ignored.
    f0 = frames;
    do_scan(1'b1);
    repeat (40) @(negedge CLOCK_50);
    check("vsync_ignored_frames", frames - f0, 32'd1);

    // Reset in the middle of a select-low phase.
    f0 = frames;
    @(posedge CLOCK_50); #1;
    v_sync_in = 1'b1;
    n = 0;
    while (n < 8) begin
      @(negedge CLOCK_50);
      n++;
      if (n == 2) v_sync_in = 1'b0;
    end
    check("mid_scan_select_low", {31'd0, sel}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_select", {31'd0, sel}, 32'd1);
    check("mid_rst_state", {20'd0, btn_state}, 32'h000);
    check("mid_rst_posedge", {20'd0, btn_posedge}, 32'h000);
    check("mid_rst_present", {31'd0, pad_present}, 32'd0);
    check("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (30) @(negedge CLOCK_50);
    check("mid_rst_no_commit", frames - f0, 32'd0);

    // Six-button pad with Z held.
    pad_type = 6; pressed = 12'h400;
    p0 = pulses;
    do_scan(1'b0);
    do_scan(1'b0);
    if (SIX) begin
      check("six_z_state", {20'd0, btn_state}, 32'h400);
      check("six_z_pulse", {20'd0, last_pulse}, 32'h400);
    end else begin
      check("six_off_state", {20'd0, btn_state}, 32'h000);
      check("six_off_pulses", pulses - p0, 32'd0);
    end
    check("six_present", {31'd0, pad_present}, 32'd1);

    repeat (5) @(negedge CLOCK_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gamepad_scanner.md
GAMEPAD_SCANNER -- requirements
Module: gamepad_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 500, meaning CLOCK_50 cycles GP_PIN7_SELECT is held in each phase before sampling (10 us).
REQ-002 SHALL have ports: CLOCK_50  in  1  system clock, 50 MHz.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: v_sync_in  in  1  frame strobe; a rising edge starts one scan.
REQ-005 SHALL have ports: GP_PIN1_UP_Z, GP_PIN2_DOWN_Y, GP_PIN3_LEFT_X, GP_PIN4_RIGHT_MODE, GP_PIN6_B_A, GP_PIN9_C_START  in  1 each  Sega pad lines, active-low.
REQ-006 SHALL have ports: GP_PIN7_SELECT  out  1  pad multiplex select.
REQ-007 SHALL have ports: btn_state  out  12  debounced, active-high; bits [0]up [1]down [2]left [3]right [4]A [5]B [6]C [7]start [8]X [9]Y [10]Z [11]mode.
REQ-008 SHALL have ports: btn_posedge  out  12  one-cycle press pulses, same bit order; bit 4 is the FSM's btn_a_posedge.
REQ-009 SHALL have ports: pad_present  out  1  pad detected on last scan.
REQ-010 SHALL have ports: frame_done  out  1  one-cycle pulse when a scan result is committed.

Function
REQ-011 SHALL pass all six pad inputs and v_sync_in through 2-flop synchronizers; all sampling uses synchronized values.
REQ-012 SHALL run FSM states IDLE, SEL_HI, SEL_LO, COMMIT (plus extended states per REQ-024); select high in IDLE, SEL_HI, COMMIT, low in SEL_LO.
REQ-013 IDLE -> SEL_HI on synchronized v_sync_in rising edge; rising edges outside IDLE SHALL be ignored, not queued.
REQ-014 Each SEL_HI/SEL_LO phase SHALL last exactly SETTLE_CYCLES cycles; sample taken on last cycle of phase.
REQ-015 SEL_HI sample: up=~PIN1, down=~PIN2, left=~PIN3, right=~PIN4, B=~PIN6, C=~PIN9.
REQ-016 SEL_LO sample: A=~PIN6, start=~PIN9; pad_present candidate = (PIN3==0 && PIN4==0).
REQ-017 COMMIT lasts one cycle, returns to IDLE; frame_done asserted in that cycle only.
REQ-018 Debounce: btn_state bit SHALL change only when two consecutive scans give the same new value.
REQ-019 btn_posedge[i] SHALL be 1 exactly in the cycle after btn_state[i] goes 0->1; never on release.
REQ-020 If pad_present candidate is 0: btn_state cleared immediately (no debounce), no posedges, debounce history cleared, pad_present=0.
REQ-021 Two presses in different bits in the same commit SHALL produce both posedge bits simultaneously.
REQ-022 Scan latency: frame_done within 2*SETTLE_CYCLES+5 cycles of v_sync_in rising at pin (6-button: 8*SETTLE_CYCLES+5).

Reset
REQ-023 On reset asserted, asynchronously: GP_PIN7_SELECT=1, btn_state=0, btn_posedge=0, pad_present=0, frame_done=0, FSM=IDLE, counters and debounce history 0; reset mid-scan aborts it with no commit; first scan after release requires a new v_sync_in rising edge.

Configuration
REQ-024 Macro GP_SIX_BUTTON_EN defined: scan SHALL run 4 high/low pairs; low phase of pair 2 with PIN1..PIN4 all 0 marks six-button pad; high phase of pair 3 samples Z=~PIN1, Y=~PIN2, X=~PIN3, mode=~PIN4, else bits 8-11 forced 0.
REQ-025 Macro undefined: single high/low pair; btn_state[11:8] and btn_posedge[11:8] tied 0.

Verification (SETTLE_CYCLES=4)
REQ-026 Reset mid-SEL_LO -> SELECT=1 within 0 cycles, all outputs 0, no frame_done.
REQ-027 Pad absent (all pins 1), 3 v_sync edges -> pad_present=0, btn_state=0, three frame_done pulses.
REQ-028 Pad present, A held (PIN6=0 in SEL_LO) for 2 scans -> btn_state[4]=1 after scan 2, btn_posedge=12'h010 for one cycle; scan 3 same -> no pulse.
REQ-029 A pressed for 1 scan only, then released -> btn_state[4] stays 0, no pulse.
REQ-030 v_sync pulse during SEL_HI -> ignored; exactly one frame_done for the scan.
REQ-031 GP_SIX_BUTTON_EN, six-button model, Z held 2 scans -> btn_state[10]=1, btn_posedge=12'h400; macro off -> bits 11:8 remain 0.
